// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with JK, up/down count, left-shift and parallel-load modes.
// Latency: q/qc/chg update 1 clk after sampling; tc/sout are combinational from q.
// Backpressure: none; en=0 holds every cell, inputs sampled on every rising edge.
module jk_reg_bank #(
  parameter int unsigned    WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qc,
  output logic             sout,
  output logic             tc,
  output logic             chg
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_SHIFT = 2'd2,
    MODE_LOAD  = 2'd3
  } mode_t;

  mode_t            mode_sel;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_nxt;
  logic             run;

  assign mode_sel = mode_t'(mode);
  assign shifted  = {q[WIDTH-2:0], sin};

  // Counter toggle mask: bit i flips when every lower bit equals the carry/borrow polarity.
  always_comb begin
    tgl = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tgl[i] = run;
      run    = run & (up ? q[i] : ~q[i]);
    end
  end

  // Every mode is expressed as per-cell J/K drives so one JK update rule serves all.
  always_comb begin
    j_eff = '0;
    k_eff = '0;
    if (en) begin
      unique case (mode_sel)
        MODE_JK: begin
          j_eff = j;
          k_eff = k;
        end
        MODE_COUNT: begin
          j_eff = tgl;
          k_eff = tgl;
        end
        MODE_SHIFT: begin
          j_eff = shifted;
          k_eff = ~shifted;
        end
        MODE_LOAD: begin
          j_eff = d;
          k_eff = ~d;
        end
        default: begin
          j_eff = '0;
          k_eff = '0;
        end
      endcase
    end
  end

  assign q_nxt = (j_eff & ~q) | (~k_eff & q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= RESET_VAL;
      chg <= 1'b0;
    end else begin
      q   <= q_nxt;
      chg <= (q_nxt != q);
    end
  end

  assign qc   = ~q;
  assign sout = q[WIDTH-1];
  assign tc   = en && (mode_sel == MODE_COUNT) && (up ? (&q) : ~(|q));

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] d;
  logic         up;
  logic         sin;
  logic [W-1:0] q;
  logic [W-1:0] qc;
  logic         sout;
  logic         tc;
  logic         chg;

  int checks;
  int errors;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .j    (j),
    .k    (k),
    .d    (d),
    .up   (up),
    .sin  (sin),
    .q    (q),
    .qc   (qc),
    .sout (sout),
    .tc   (tc),
    .chg  (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [W-1:0] v);
    en = 1'b1; mode = 2'd3; d = v;
    step();
  endtask

  task automatic test_reset();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL rst_q got %h want %h", q, 4'h0); end
    checks++; if (qc !== 4'hF) begin errors++; $display("FAIL rst_qc got %h want %h", qc, 4'hF); end
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL rst_chg got %b want 0", chg); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL rst_sout got %b want 0", sout); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL rst_tc got %b want 0", tc); end
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 2'd1; up = 1'b1;
    repeat (9) step();
    checks++; if (q !== 4'h9) begin errors++; $display("FAIL ar_count got %h want %h", q, 4'h9); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL ar_q got %h want %h", q, 4'h0); end
    checks++; if (qc !== 4'hF) begin errors++; $display("FAIL ar_qc got %h want %h", qc, 4'hF); end
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL ar_chg got %b want 0", chg); end
    #1 rst_n = 1'b1;
    step();
    checks++; if (q !== 4'h1) begin errors++; $display("FAIL ar_resume1 got %h want %h", q, 4'h1); end
    step();
    checks++; if (q !== 4'h2) begin errors++; $display("FAIL ar_resume2 got %h want %h", q, 4'h2); end
  endtask

  task automatic test_jk();
    load_val(4'b0101);
    mode = 2'd0; j = 4'b1100; k = 4'b1010;
    step();
    checks++; if (q !== 4'b1101) begin errors++; $display("FAIL jk_q got %b want %b", q, 4'b1101); end
    checks++; if (qc !== 4'b0010) begin errors++; $display("FAIL jk_qc got %b want %b", qc, 4'b0010); end
    checks++; if (chg !== 1'b1) begin errors++; $display("FAIL jk_chg got %b want 1", chg); end
    j = 4'h0; k = 4'h0;
    step();
    checks++; if (q !== 4'b1101) begin errors++; $display("FAIL jk_hold got %b want %b", q, 4'b1101); end
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL jk_hold_chg got %b want 0", chg); end
  endtask

  task automatic test_count_wrap();
    load_val(4'hE);
    mode = 2'd1; up = 1'b1;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_e got %b want 0", tc); end
    step();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL up_f got %h want %h", q, 4'hF); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL up_tc_f got %b want 1", tc); end
    step();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL up_wrap got %h want %h", q, 4'h0); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_0 got %b want 0", tc); end

    load_val(4'h1);
    mode = 2'd1; up = 1'b0;
    step();
    checks++; if (q !== 4'h0) begin errors++; $display("FAIL dn_0 got %h want %h", q, 4'h0); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL dn_tc_0 got %b want 1", tc); end
    step();
    checks++; if (q !== 4'hF) begin errors++; $display("FAIL dn_wrap got %h want %h", q, 4'hF); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dn_tc_f got %b want 0", tc); end

    load_val(4'h5);
    mode = 2'd1; up = 1'b1; en = 1'b0;
    step();
    checks++; if (q !== 4'h5) begin errors++; $display("FAIL en_hold got %h want %h", q, 4'h5); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL en_tc got %b want 0", tc); end
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL en_chg got %b want 0", chg); end
  endtask

  task automatic test_shift();
    load_val(4'b1001);
    mode = 2'd2; sin = 1'b1;
    #1;
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL sh_sout_pre got %b want 1", sout); end
    step();
    checks++; if (q !== 4'b0011) begin errors++; $display("FAIL sh_q1 got %b want %b", q, 4'b0011); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL sh_sout_post got %b want 0", sout); end
    sin = 1'b0;
    step();
    checks++; if (q !== 4'b0110) begin errors++; $display("FAIL sh_q2 got %b want %b", q, 4'b0110); end
  endtask

  task automatic test_load_enable();
    en = 1'b0; mode = 2'd3; d = 4'hA;
    step();
    checks++; if (q !== 4'b0110) begin errors++; $display("FAIL ld_dis got %h want %h", q, 4'h6); end
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL ld_dis_chg got %b want 0", chg); end
    en = 1'b1;
    step();
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL ld_q got %h want %h", q, 4'hA); end
    checks++; if (chg !== 1'b1) begin errors++; $display("FAIL ld_chg got %b want 1", chg); end
    step();
    checks++; if (q !== 4'hA) begin errors++; $display("FAIL ld_same got %h want %h", q, 4'hA); end
    checks++; if (chg !== 1'b0) begin errors++; $display("FAIL ld_same_chg got %b want 0", chg); end
  endtask

  task automatic test_back_to_back_toggle();
    logic [W-1:0] exp_q;
    load_val(4'h3);
    mode = 2'd0; j = 4'hF; k = 4'hF;
    exp_q = 4'h3;
    for (int i = 0; i < 6; i++) begin
      exp_q = ~exp_q;
      step();
      checks++; if (q !== exp_q) begin errors++; $display("FAIL tg_q[%0d] got %h want %h", i, q, exp_q); end
      checks++; if (qc !== ~exp_q) begin errors++; $display("FAIL tg_qc[%0d] got %h want %h", i, qc, ~exp_q); end
      checks++; if (chg !== 1'b1) begin errors++; $display("FAIL tg_chg[%0d] got %b want 1", i, chg); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; en = 1'b0; mode = 2'd0;
    j = '0; k = '0; d = '0; up = 1'b0; sin = 1'b0;
    #12;
    test_reset();
    test_async_reset();
    test_jk();
    test_count_wrap();
    test_shift();
    test_load_enable();
    test_back_to_back_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised WIDTH-bit register bank built from JK flip-flop cells, generalising the single-bit JK flip-flop to a multi-bit, multi-mode storage element. Per-bit JK control is the base mode. Three additional modes reuse the same cells: synchronous up/down counter, left shift register, and parallel load. Used wherever the design needs a small configurable state register with complement outputs and a change indication.

## Interface
- WIDTH, 8, number of JK cells (≥2)
- RESET_VAL, {WIDTH{1'b0}}, value forced onto q while reset is asserted

- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  update enable; 0 = every cell holds
- mode  in  2  0 = JK, 1 = COUNT, 2 = SHIFT, 3 = LOAD
- j  in  WIDTH  per-bit J inputs (JK mode only)
- k  in  WIDTH  per-bit K inputs (JK mode only)
- d  in  WIDTH  parallel load data (LOAD mode only)
- up  in  1  count direction (COUNT mode): 1 = up, 0 = down
- sin  in  1  serial input to bit 0 (SHIFT mode)
- q  out  WIDTH  register state
- qc  out  WIDTH  bitwise complement of q
- sout  out  1  serial output, = q[WIDTH-1]
- tc  out  1  terminal count indication (combinational)
- chg  out  1  registered pulse: q changed on the previous edge

## Operation
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- en=0: q holds in every mode. chg goes to 0 on the next edge.
- **JK mode (0)**, per bit i, with (j[i],k[i]):
  - 00: hold
  - 10: set to 1
  - 01: clear to 0
  - 11: toggle
- **COUNT mode (1)**:
  - up=1: q ← q+1, modulo 2^WIDTH (all-ones wraps to 0).
  - up=0: q ← q−1 (0 wraps to all-ones).
  - Implemented as JK toggles: bit i toggles when all lower bits are 1 (up) or all 0 (down).
- **SHIFT mode (2)**: q ← {q[WIDTH-2:0], sin}. The old q[WIDTH-1] is lost. It was visible on sout before the edge.
- **LOAD mode (3)**: q ← d.
- j, k, d, up and sin are ignored outside their own mode.
- **qc**: always exactly ~q, including during reset. Never equal to q in any bit.
- **tc**: 1 iff en=1, mode=COUNT, and either (up=1, q=all-ones) or (up=0, q=0). Otherwise 0. It flags that the next edge wraps.
- **chg**: on each edge, chg ← (next q ≠ current q). A hold, a JK set on an already-1 bit, or a LOAD of an equal value produces chg=0.
- **Mode change**: takes effect on the same edge it is sampled. No pipeline or internal FSM state beyond q and chg.

## Timing
- **Reset values**: q=RESET_VAL, qc=~RESET_VAL, chg=0, sout=RESET_VAL[WIDTH-1]. tc follows the combinational rule from q.
- **Reset assertion**: asynchronous. Outputs take their reset values immediately, mid-operation in any mode, without waiting for clk.
- **Reset deassertion**: the first update occurs on the first rising clk edge with rst_n=1.
- **Latency**:
  - q and qc: 1 clock from input sampling.
  - chg: asserted in the cycle following the edge that changed q; lasts one cycle per changing edge. It stays high continuously if q changes every cycle.
  - tc and sout: combinational from registered q and the current inputs. No added latency.
- **Inputs**: sampled only at the rising edge and must be stable around it. No handshake.

## Test plan
- **Async reset** (WIDTH=4): COUNT up to q=4'h9, drop rst_n between edges → q=0, qc=4'hF, chg=0 immediately. Release rst_n → counting resumes 1, 2, … from 0.
- **JK mode**: q=4'b0101, j=4'b1100, k=4'b1010, en=1, one edge → q=4'b1101, qc=4'b0010; chg=1 for one cycle. Repeat with j=k=0 → q holds, chg=0.
- **COUNT wrap**:
  - up=1 from 4'hE → E, F (tc=1 while q=F), 0 (tc=0).
  - up=0 from 4'h1 → 0 (tc=1), F.
  - Toggle en low at q=5 → q stays 5, tc=0.
- **SHIFT**: q=4'b1001, sin=1 → 4'b0011, with sout=1 before the edge and 0 after. Then sin=0 → 4'b0110.
- **LOAD / enable**: d=4'hA with en=0 → q unchanged, chg=0. en=1 → q=4'hA, chg=1. Reload 4'hA → chg=0.
- **Continuous toggle**: JK mode, j=k=4'hF for 6 edges from q=4'h3 → q alternates C, 3, C, …; chg stays 1 and qc=~q every cycle.
